io_tx_controller: RTL and testbench
===================================

# io_tx_controller

Streams a stored image out of image SRAM in raster order (row 0 col 0 first, col fastest) as a byte stream with valid/ready flow control. It is the readout stage downstream of the receive path that fills image SRAM, and it sits between the SRAM and the chip output pins. A 2-entry skid FIFO absorbs the SRAM read latency, so the block sustains 1 byte/cycle under backpressure without dropping or duplicating data.

## Interface
- No parameters. Fixed widths: 8-bit data, 8-bit row/col.
- `sram_img.clk`  input (via interface)  1  sole clock; used internally as `clk`; all logic on the rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `en`  input  1  start request; sampled only in IDLE.
- `nrows`  input  8  image height in rows; latched at start.
- `ncols`  input  8  image width in columns; latched at start.
- `busy`  output  1  high from start until the last byte has been handshaken.
- `done`  output  1  one-cycle pulse on frame completion.
- `dout`  output  8  stream data, driven from the FIFO head.
- `dout_valid`  output  1  FIFO non-empty.
- `dout_ready`  input  1  consumer accepts; a transfer occurs when valid && ready.
- `sram_img`  `img_sram_intf.mst`  —  drives `write_en`=0 (constant), `sense_en`, `row`, `col`; reads `dout`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `busy`=0. If `en`=1 and both dims ≠ 0: latch dims, clear rd_row/rd_col, go to RUN.
  - IDLE with `en`=1 and `nrows`=0 or `ncols`=0: stay in IDLE, issue no reads, pulse `done` in the next cycle.
  - RUN: issue reads. After the read of (nrows-1, ncols-1) is issued, go to DRAIN.
  - DRAIN: issue no reads. When the FIFO is empty, inflight=0, and the final byte has transferred, go to IDLE and pulse `done`.
- Read issue: `sense_en`=1 with `row`/`col`=rd_row/rd_col in a cycle iff state=RUN and (fifo_count + inflight − pop) < 2. Here pop = dout_valid && dout_ready.
  - Address advance on issue: col+1; at ncols-1, col←0 and row+1.
  - Internal counters are 9 bits, so last-index compares never wrap at 255.
- inflight is 1 in the cycle after an issue. `sram_img.dout` is valid in that cycle and is pushed into the FIFO.
- FIFO: 2 entries. Push and pop may occur in the same cycle. It never overflows, because the credit rule above guarantees space. `dout` is stable while `dout_valid`=1 and `dout_ready`=0.
- `en` is ignored while `busy`=1. `nrows`/`ncols` changes after the start edge have no effect.

## Timing
- Reset values (asynchronous): state=IDLE, `busy`=0, `done`=0, `dout_valid`=0, `dout`=0, `sense_en`=0, `row`=0, `col`=0, FIFO empty, inflight=0.
- Reset mid-frame: the frame is abandoned immediately. No `done` pulse. The next `en` after reset release starts a new frame.
- Start to first data: with `en` sampled at edge E0, the first read is issued in the cycle after E0. Data is pushed at E2. `dout_valid`=1 after E2.
- Throughput: with `dout_ready` held high, one byte per cycle. A full frame takes nrows·ncols + 2 cycles from E0 to the last transfer.
- `busy` rises after E0 and falls on the same edge that `done` rises, i.e. the edge after the final transfer.
- `done` is high for exactly one cycle.

## Configuration
- `IO_TX_MARKERS_EN` defined: adds outputs `dout_sof` (first byte of frame) and `dout_eol` (last column of each row). Each marker travels through the FIFO alongside its byte and is valid under `dout_valid`.
- `IO_TX_MARKERS_EN` undefined: these ports and the FIFO tag bits are absent. All other behaviour is identical.

## Test plan
- SRAM preloaded with byte = row·16+col; nrows=4, ncols=5, `dout_ready`=1 → 20 bytes 0x00..0x04, 0x10.., …, 0x34 on consecutive cycles. `done` pulses once; `busy` spans 22 cycles.
- Same frame with `dout_ready` toggled pseudo-randomly (including held low for 10 cycles) → identical byte sequence, no drops or duplicates, `dout` stable while stalled, `sense_en` never issued with 2 entries pending.
- nrows=0 or ncols=0 with `en`=1 → no `sense_en`, `busy` stays 0, `done` pulses once the next cycle.
- nrows=255, ncols=255 → 65025 bytes; the last read address is (254,254); no address wrap.
- `rstn` asserted after 7 bytes → `dout_valid`, `busy` and `sense_en` drop asynchronously, no `done`. A new `en` then restarts at (0,0).
- With `IO_TX_MARKERS_EN`, 2×3 frame → `dout_sof` on byte 0 only; `dout_eol` on bytes 2 and 5.

Source files
------------

// File: rtl/io_tx_controller_if.sv
// img_sram_intf: image SRAM access port.
// The master drives the read strobe and address; read data returns one cycle later.
interface img_sram_intf (input logic clk);
    logic       write_en;
    logic       sense_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] dout;

    modport mst (input clk, input dout, output write_en, output sense_en, output row, output col);
    modport slv (input clk, input write_en, input sense_en, input row, input col, output dout);
endinterface

// File: rtl/io_tx_controller.sv
// io_tx_controller: streams a stored image out of image SRAM in raster order
// as a valid/ready byte stream. A 2-entry skid FIFO absorbs the one-cycle
// SRAM read latency, so the block sustains one byte per cycle under backpressure.
// Optional feature macro: IO_TX_MARKERS_EN adds dout_sof/dout_eol frame markers.
module io_tx_controller (
    img_sram_intf.mst  sram_img,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] nrows,
    input  logic [7:0] ncols,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready
`ifdef IO_TX_MARKERS_EN
    ,
    output logic       dout_sof,
    output logic       dout_eol
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

`ifdef IO_TX_MARKERS_EN
    localparam int unsigned EW = 10;   // {sof, eol, data}
`else
    localparam int unsigned EW = 8;
`endif

    logic clk;
    assign clk = sram_img.clk;

    state_t        state_q, state_d;
    logic [8:0]    nrows_q, nrows_d, ncols_q, ncols_d;
    logic [8:0]    rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [EW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [EW-1:0] push_word;
    logic          pop, issue, last_col, last_row;
    logic [2:0]    occ;
`ifdef IO_TX_MARKERS_EN
    logic [1:0]    tag_q, tag_d;
`endif

    // Read credit: never let FIFO entries plus the in-flight read exceed two
    always_comb begin
        pop      = (cnt_q != 2'd0) && dout_ready;
        occ      = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue    = (state_q == RUN) && (occ < 3'd2);
        last_col = (rd_col_q == ncols_q - 9'd1);
        last_row = (rd_row_q == nrows_q - 9'd1);
    end

`ifdef IO_TX_MARKERS_EN
    // Marker bits captured at issue time so they travel with their byte
    always_comb begin
        tag_d = {(rd_row_q == 9'd0) && (rd_col_q == 9'd0), last_col};
    end
    assign push_word = {tag_q, sram_img.dout};
    assign dout_sof  = e0_q[9];
    assign dout_eol  = e0_q[8];
`else
    assign push_word = sram_img.dout;
`endif

    // Frame FSM: start/latch, raster address walk, drain and completion
    always_comb begin
        state_d    = state_q;
        nrows_d    = nrows_q;
        ncols_d    = ncols_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        done_d     = 1'b0;
        inflight_d = issue;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (nrows == 8'd0 || ncols == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        nrows_d  = {1'b0, nrows};
                        ncols_d  = {1'b0, ncols};
                        rd_row_d = '0;
                        rd_col_d = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (last_col) begin
                        rd_col_d = '0;
                        if (last_row) state_d = DRAIN;
                        else          rd_row_d = rd_row_q + 9'd1;
                    end else begin
                        rd_col_d = rd_col_q + 9'd1;
                    end
                end
            end
            DRAIN: begin
                // Leave on the edge that completes the final transfer
                if (!inflight_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid FIFO: e0 is the head; simultaneous push and pop keep the count
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_word;
                else               e1_d = push_word;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = push_word;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_word;
                end
            end
            default: ;
        endcase
    end

    // State, counters and FIFO storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            nrows_q    <= '0;
            ncols_q    <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
`ifdef IO_TX_MARKERS_EN
            tag_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            nrows_q    <= nrows_d;
            ncols_q    <= ncols_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
`ifdef IO_TX_MARKERS_EN
            tag_q      <= tag_d;
`endif
        end
    end

    assign sram_img.write_en = 1'b0;
    assign sram_img.sense_en = issue;
    assign sram_img.row      = rd_row_q[7:0];
    assign sram_img.col      = rd_col_q[7:0];
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign dout              = e0_q[7:0];
    assign dout_valid        = (cnt_q != 2'd0);
endmodule

// File: tb/tb_io_tx_controller.sv
// Directed bench for io_tx_controller: SRAM model returns row*16+col one
// cycle after each read strobe; a negedge monitor records the output stream.
module tb_io_tx_controller;
    logic       clk = 1'b0;
    logic       rstn, en, dout_ready;
    logic [7:0] nrows, ncols;
    logic       busy, done, dout_valid;
    logic [7:0] dout;
`ifdef IO_TX_MARKERS_EN
    logic       dout_sof, dout_eol;
`endif

    always #5 clk = ~clk;

    img_sram_intf sram_if (.clk(clk));

    io_tx_controller dut (
        .sram_img   (sram_if),
        .rstn       (rstn),
        .en         (en),
        .nrows      (nrows),
        .ncols      (ncols),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef IO_TX_MARKERS_EN
        ,
        .dout_sof   (dout_sof),
        .dout_eol   (dout_eol)
`endif
    );

    // SRAM model: registered read, content = (row*16 + col) mod 256
    always @(posedge clk) begin
        if (sram_if.sense_en) sram_if.dout <= (sram_if.row << 4) + sram_if.col;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Written by the test tasks only
    int n_chk = 0, n_pass = 0;
    int clr_req = 0, mon_ncols = 1, e0_cyc = 0;

    // Written by the monitor only
    int seen_clr = 0;
    int issued_n, xfer_n, busy_n, done_n, byte_err, addr_err, stab_err, credit_err;
    int first_xfer, last_xfer, done_at, ar, ac;
    logic [7:0] last_r, last_c, prev_dout, exp_b;
    logic prev_stall;
    logic [7:0] bq[$];
    logic [63:0] sof_v, eol_v;

    initial begin
        forever begin
            @(negedge clk);
            if (clr_req != seen_clr) begin
                seen_clr = clr_req;
                issued_n = 0; xfer_n = 0; busy_n = 0; done_n = 0;
                byte_err = 0; addr_err = 0; stab_err = 0; credit_err = 0;
                first_xfer = -1; last_xfer = -1; done_at = -1; ar = 0; ac = 0;
                last_r = 8'h00; last_c = 8'h00; prev_stall = 1'b0;
                bq.delete(); sof_v = '0; eol_v = '0;
            end
            if (!rstn) begin
                issued_n = 0; xfer_n = 0; prev_stall = 1'b0; ar = 0; ac = 0;
            end else begin
                if (busy) busy_n++;
                if (done) begin done_n++; done_at = cyc - e0_cyc; end
                if (prev_stall && !(dout_valid === 1'b1 && dout === prev_dout)) stab_err++;
                if (sram_if.sense_en) begin
                    if (issued_n - xfer_n - ((dout_valid && dout_ready) ? 1 : 0) >= 2) credit_err++;
                    if (sram_if.row !== 8'(ar) || sram_if.col !== 8'(ac)) addr_err++;
                    last_r = sram_if.row; last_c = sram_if.col;
                    ac++;
                    if (ac == mon_ncols) begin ac = 0; ar++; end
                    issued_n++;
                end
                if (dout_valid && dout_ready) begin
                    exp_b = 8'((xfer_n / mon_ncols) * 16 + (xfer_n % mon_ncols));
                    if (dout !== exp_b) byte_err++;
                    bq.push_back(dout);
`ifdef IO_TX_MARKERS_EN
                    if (xfer_n < 64) begin sof_v[xfer_n] = dout_sof; eol_v[xfer_n] = dout_eol; end
`endif
                    if (first_xfer < 0) first_xfer = cyc - e0_cyc + 1;
                    last_xfer = cyc - e0_cyc + 1;
                    xfer_n++;
                end
                prev_stall = dout_valid && !dout_ready;
                prev_dout  = dout;
            end
        end
    end

    // Pulse en for one cycle; dims are scrambled afterwards to prove they were latched
    task automatic start_frame(input logic [7:0] nr, input logic [7:0] nc);
        clr_req++;
        mon_ncols = (nc == 8'd0) ? 1 : int'(nc);
        @(posedge clk); #1;
        nrows = nr; ncols = nc; en = 1'b1;
        @(posedge clk); #1;
        e0_cyc = cyc;
        en = 1'b0; nrows = 8'hAA; ncols = 8'h55;
    endtask

    task automatic wait_done(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (done_n > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b1; en = 1'b0; dout_ready = 1'b0; nrows = 8'd0; ncols = 8'd0;
        #2 rstn = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else n_pass++;
        n_chk++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
        n_chk++; if (sram_if.sense_en !== 1'b0) $display("FAIL reset_sense: got %b want 0", sram_if.sense_en); else n_pass++;
        n_chk++; if ({sram_if.row, sram_if.col} !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", {sram_if.row, sram_if.col}); else n_pass++;
        n_chk++; if (sram_if.write_en !== 1'b0) $display("FAIL reset_wen: got %b want 0", sram_if.write_en); else n_pass++;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_stream;
        logic ok;
        dout_ready = 1'b1;
        start_frame(8'd4, 8'd5);
        n_chk++; if (sram_if.sense_en !== 1'b1) $display("FAIL stream_first_issue: got %b want 1", sram_if.sense_en); else n_pass++;
        n_chk++; if ({sram_if.row, sram_if.col} !== 16'h0000) $display("FAIL stream_first_addr: got %h want 0000", {sram_if.row, sram_if.col}); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL stream_busy_rise: got %b want 1", busy); else n_pass++;
        wait_done(100, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL stream_timeout: got %b want 1", ok); else n_pass++;
        n_chk++; if (bq.size() != 20) $display("FAIL stream_count: got %0d want 20", bq.size()); else n_pass++;
        n_chk++; if (byte_err != 0) $display("FAIL stream_bytes: got %0d bad want 0", byte_err); else n_pass++;
        n_chk++; if (bq.size() > 19 && (bq[5] !== 8'h10 || bq[19] !== 8'h34)) $display("FAIL stream_b5_b19: got %h %h want 10 34", bq[5], bq[19]); else n_pass++;
        n_chk++; if (first_xfer != 3) $display("FAIL stream_first_xfer: got %0d want 3", first_xfer); else n_pass++;
        n_chk++; if (last_xfer != 22) $display("FAIL stream_last_xfer: got %0d want 22", last_xfer); else n_pass++;
        n_chk++; if (busy_n != 22) $display("FAIL stream_busy_len: got %0d want 22", busy_n); else n_pass++;
        n_chk++; if (done_n != 1) $display("FAIL stream_done_cnt: got %0d want 1", done_n); else n_pass++;
        n_chk++; if (done_at != 22) $display("FAIL stream_done_edge: got %0d want 22", done_at); else n_pass++;
        n_chk++; if (addr_err != 0 || issued_n != 20) $display("FAIL stream_reads: got err %0d n %0d want 0 20", addr_err, issued_n); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [15:0] pat;
        logic ok;
        pat = 16'b1011_0010_1110_0101;
        ok = 1'b0;
        clr_req++;
        mon_ncols = 5;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (i == 1) e0_cyc = cyc;
            en    = (i == 0);
            nrows = (i == 0) ? 8'd4 : 8'hAA;
            ncols = (i == 0) ? 8'd5 : 8'h55;
            dout_ready = (i >= 6 && i < 16) ? 1'b0 : pat[i % 16];
            if (done_n > 0) begin ok = 1'b1; break; end
        end
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (ok !== 1'b1) $display("FAIL bp_timeout: got %b want 1", ok); else n_pass++;
        n_chk++; if (bq.size() != 20) $display("FAIL bp_count: got %0d want 20", bq.size()); else n_pass++;
        n_chk++; if (byte_err != 0) $display("FAIL bp_bytes: got %0d bad want 0", byte_err); else n_pass++;
        n_chk++; if (stab_err != 0) $display("FAIL bp_stable: got %0d unstable want 0", stab_err); else n_pass++;
        n_chk++; if (credit_err != 0) $display("FAIL bp_credit: got %0d over-issue want 0", credit_err); else n_pass++;
        n_chk++; if (done_n != 1) $display("FAIL bp_done_cnt: got %0d want 1", done_n); else n_pass++;
    endtask

    task automatic test_zero_dims;
        logic [7:0] zr [2];
        logic [7:0] zc [2];
        zr[0] = 8'd0; zc[0] = 8'd5;
        zr[1] = 8'd3; zc[1] = 8'd0;
        for (int k = 0; k < 2; k++) begin
            start_frame(zr[k], zc[k]);
            n_chk++; if (done !== 1'b1) $display("FAIL zero%0d_done: got %b want 1", k, done); else n_pass++;
            n_chk++; if (busy !== 1'b0 || sram_if.sense_en !== 1'b0) $display("FAIL zero%0d_idle: got busy %b sense %b want 0 0", k, busy, sram_if.sense_en); else n_pass++;
            @(posedge clk); #1;
            n_chk++; if (done !== 1'b0) $display("FAIL zero%0d_pulse: got %b want 0", k, done); else n_pass++;
            repeat (3) @(posedge clk);
            #1;
            n_chk++; if (issued_n != 0 || busy_n != 0 || done_n != 1) $display("FAIL zero%0d_quiet: got reads %0d busy %0d done %0d want 0 0 1", k, issued_n, busy_n, done_n); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic ok;
        dout_ready = 1'b1;
        start_frame(8'd4, 8'd5);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (xfer_n >= 7) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_chk++; if (ok !== 1'b1) $display("FAIL rmid_timeout: got %b want 1", ok); else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_chk++; if (dout_valid !== 1'b0 || busy !== 1'b0 || sram_if.sense_en !== 1'b0) $display("FAIL rmid_async: got v %b b %b s %b want 0 0 0", dout_valid, busy, sram_if.sense_en); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (done_n != 0) $display("FAIL rmid_no_done: got %0d want 0", done_n); else n_pass++;
        start_frame(8'd2, 8'd3);
        n_chk++; if (sram_if.sense_en !== 1'b1 || {sram_if.row, sram_if.col} !== 16'h0000) $display("FAIL rmid_restart: got s %b addr %h want 1 0000", sram_if.sense_en, {sram_if.row, sram_if.col}); else n_pass++;
        wait_done(100, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rmid_timeout2: got %b want 1", ok); else n_pass++;
        n_chk++; if (bq.size() != 6 || byte_err != 0) $display("FAIL rmid_frame: got n %0d err %0d want 6 0", bq.size(), byte_err); else n_pass++;
        n_chk++; if (bq.size() > 3 && bq[3] !== 8'h10) $display("FAIL rmid_b3: got %h want 10", bq[3]); else n_pass++;
    endtask

    task automatic test_max_dims;
        logic ok;
        dout_ready = 1'b1;
        start_frame(8'd255, 8'd255);
        wait_done(66000, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL max_timeout: got %b want 1", ok); else n_pass++;
        n_chk++; if (bq.size() != 65025) $display("FAIL max_count: got %0d want 65025", bq.size()); else n_pass++;
        n_chk++; if (byte_err != 0) $display("FAIL max_bytes: got %0d bad want 0", byte_err); else n_pass++;
        n_chk++; if (last_r !== 8'd254 || last_c !== 8'd254) $display("FAIL max_last_addr: got %0d,%0d want 254,254", last_r, last_c); else n_pass++;
        n_chk++; if (addr_err != 0 || issued_n != 65025) $display("FAIL max_reads: got err %0d n %0d want 0 65025", addr_err, issued_n); else n_pass++;
        n_chk++; if (last_xfer != 65027) $display("FAIL max_last_xfer: got %0d want 65027", last_xfer); else n_pass++;
    endtask

`ifdef IO_TX_MARKERS_EN
    task automatic test_markers;
        logic ok;
        dout_ready = 1'b1;
        start_frame(8'd2, 8'd3);
        wait_done(100, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL mark_timeout: got %b want 1", ok); else n_pass++;
        n_chk++; if (sof_v[5:0] !== 6'b000001) $display("FAIL mark_sof: got %b want 000001", sof_v[5:0]); else n_pass++;
        n_chk++; if (eol_v[5:0] !== 6'b100100) $display("FAIL mark_eol: got %b want 100100", eol_v[5:0]); else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_zero_dims;
        test_reset_mid;
`ifdef IO_TX_MARKERS_EN
        test_markers;
`endif
        test_max_dims;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
